// File: rtl/seven_seg_scan_pkg.sv
// Shared constants for the seven-segment scan driver: segment bit positions,
// active-high hex glyph patterns and the double-buffered display word layout.
package seg_pkg;

    localparam int NUM_DIGITS = 4;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [6:0] HEX_0 = 7'h3F;
    localparam logic [6:0] HEX_1 = 7'h06;
    localparam logic [6:0] HEX_2 = 7'h5B;
    localparam logic [6:0] HEX_3 = 7'h4F;
    localparam logic [6:0] HEX_4 = 7'h66;
    localparam logic [6:0] HEX_5 = 7'h6D;
    localparam logic [6:0] HEX_6 = 7'h7D;
    localparam logic [6:0] HEX_7 = 7'h07;
    localparam logic [6:0] HEX_8 = 7'h7F;
    localparam logic [6:0] HEX_9 = 7'h6F;
    localparam logic [6:0] HEX_A = 7'h77;
    localparam logic [6:0] HEX_B = 7'h7C;
    localparam logic [6:0] HEX_C = 7'h39;
    localparam logic [6:0] HEX_D = 7'h5E;
    localparam logic [6:0] HEX_E = 7'h79;
    localparam logic [6:0] HEX_F = 7'h71;

    typedef struct packed {
        logic [NUM_DIGITS-1:0] dp;
        logic [15:0]           value;
    } disp_t;

endpackage

// File: rtl/seven_seg_scan_if.sv
// Bus between the CPU display output (master) and the scan driver (slave).
interface seven_seg_scan_if;

    logic [15:0] value;
    logic [3:0]  dp;
    logic        load;
    logic [3:0]  digit_en;
    logic        pending;
    logic        frame_tick;
    logic [7:0]  io_seg;
    logic [3:0]  io_sel;

    modport master (
        output value, dp, load, digit_en,
        input  pending, frame_tick, io_seg, io_sel
    );

    modport slave (
        input  value, dp, load, digit_en,
        output pending, frame_tick, io_seg, io_sel
    );

endinterface

// File: rtl/seven_seg_scan_hex_to_seg.sv
// Combinational hex nibble to seven-segment decoder, active-high, bits g..a.
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (nibble_i)
            4'h0: seg_o = HEX_0;
            4'h1: seg_o = HEX_1;
            4'h2: seg_o = HEX_2;
            4'h3: seg_o = HEX_3;
            4'h4: seg_o = HEX_4;
            4'h5: seg_o = HEX_5;
            4'h6: seg_o = HEX_6;
            4'h7: seg_o = HEX_7;
            4'h8: seg_o = HEX_8;
            4'h9: seg_o = HEX_9;
            4'hA: seg_o = HEX_A;
            4'hB: seg_o = HEX_B;
            4'hC: seg_o = HEX_C;
            4'hD: seg_o = HEX_D;
            4'hE: seg_o = HEX_E;
            4'hF: seg_o = HEX_F;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed seven-segment driver with inter-digit blanking and
// frame-synchronous value commit. Define SEG_LZB_EN for leading-zero blanking.
module seven_seg_scan
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic              clk,
    input  logic              rst,
    seven_seg_scan_if.slave   bus
);

    localparam int              CNT_W     = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
    localparam logic [7:0]       SEG_POL   = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [3:0]       SEL_POL   = (ACTIVE_LOW != 0) ? 4'hF : 4'h0;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       digit_q, digit_d;
    disp_t            disp_q, disp_d;
    disp_t            pend_q, pend_d;
    logic             pending_q, pending_d;
    logic             tick_q, tick_d;
    logic [3:0]       sel_q, sel_d;
    logic [7:0]       seg_q, seg_d;

    logic             wrap;
    logic [3:0]       nibble;
    logic [6:0]       seg7;
    logic [6:0]       glyph;

    assign wrap   = (cnt_q == CNT_MAX) && (digit_q == 2'd3);
    assign nibble = disp_q.value[{digit_q, 2'b00} +: 4];

    hex_to_seg u_hex_to_seg (
        .nibble_i (nibble),
        .seg_o    (seg7)
    );

`ifdef SEG_LZB_EN
    // A digit is a leading zero when it and every digit to its left are zero.
    logic [NUM_DIGITS-1:0] lead_zero;

    always_comb begin
        lead_zero    = '0;
        lead_zero[3] = (disp_q.value[15:12] == 4'h0);
        lead_zero[2] = lead_zero[3] && (disp_q.value[11:8] == 4'h0);
        lead_zero[1] = lead_zero[2] && (disp_q.value[7:4] == 4'h0);
    end

    assign glyph = lead_zero[digit_q] ? SEG_BLANK : seg7;
`else
    assign glyph = seg7;
`endif

    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        cnt_d     = cnt_q + 1'b1;
        digit_d   = digit_q;
        disp_d    = disp_q;
        pend_d    = pend_q;
        pending_d = pending_q;
        tick_d    = wrap;
        sel_d     = '0;
        seg_d     = '0;

        if (cnt_q == CNT_MAX) begin
            cnt_d   = '0;
            digit_d = digit_q + 2'd1;
        end

        if (bus.load) begin
            pend_d    = '{dp: bus.dp, value: bus.value};
            pending_d = 1'b1;
        end

        // Commit uses the pend contents from before this cycle's load.
        if (wrap && pending_q) begin
            disp_d    = pend_q;
            pending_d = bus.load;
        end

        if ((cnt_q >= BLANK_END) && bus.digit_en[digit_q]) begin
            sel_d                = 4'b0001 << digit_q;
            seg_d[SEG_G:SEG_A]   = glyph;
            seg_d[SEG_DP]        = disp_q.dp[digit_q];
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            digit_q   <= '0;
            disp_q    <= '0;
            pend_q    <= '0;
            pending_q <= 1'b0;
            tick_q    <= 1'b0;
            sel_q     <= SEL_POL;
            seg_q     <= SEG_POL;
        end else begin
            cnt_q     <= cnt_d;
            digit_q   <= digit_d;
            disp_q    <= disp_d;
            pend_q    <= pend_d;
            pending_q <= pending_d;
            tick_q    <= tick_d;
            sel_q     <= sel_d ^ SEL_POL;
            seg_q     <= seg_d ^ SEG_POL;
        end
    end

    assign bus.pending    = pending_q;
    assign bus.frame_tick = tick_q;
    assign bus.io_sel     = sel_q;
    assign bus.io_seg     = seg_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with REFRESH_DIV=8, BLANK_CYCLES=2, active-low.
// Define SEG_LZB_EN on both RTL and bench to exercise leading-zero blanking.
module tb_seven_seg_scan;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    seven_seg_scan_if bus ();

    seven_seg_scan #(
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2),
        .ACTIVE_LOW   (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One digit slot as seen on the outputs: 2 blank cycles, then 6 lit cycles.
    task automatic check_slot(input string tag, input logic [3:0] sel, input logic [7:0] seg);
        for (int i = 0; i < 8; i++) begin
            step();
            if (i < 2) begin
                chk({tag, " blank sel"}, {4'h0, bus.io_sel}, 8'h0F);
                chk({tag, " blank seg"}, bus.io_seg, 8'hFF);
            end else begin
                chk({tag, " sel"}, {4'h0, bus.io_sel}, {4'h0, sel});
                chk({tag, " seg"}, bus.io_seg, seg);
            end
        end
    endtask

    task automatic wait_tick(input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (bus.frame_tick !== 1'b1 && n < 40);
        chk({tag, " frame_tick"}, {7'h0, bus.frame_tick}, 8'h01);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        bus.value = v;
        bus.dp    = d;
        bus.load  = 1'b1;
        step();
        bus.load  = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        bus.value    = 16'h1234;
        bus.dp       = 4'hF;
        bus.load     = 1'b1;
        bus.digit_en = 4'hF;

        // Reset held 3 cycles with load asserted.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst sel", {4'h0, bus.io_sel}, 8'h0F);
            chk("rst seg", bus.io_seg, 8'hFF);
            chk("rst pending", {7'h0, bus.pending}, 8'h00);
            chk("rst tick", {7'h0, bus.frame_tick}, 8'h00);
        end
        rst      = 1'b0;
        bus.load = 1'b0;

        // Cycle 0 -> 1, then load 1234 with dp on digit0 during cycle 1.
        step();
        do_load(16'h1234, 4'b0001);
        for (int t = 2; t < 32; t++) begin
            chk("wait pending", {7'h0, bus.pending}, 8'h01);
            chk("wait tick", {7'h0, bus.frame_tick}, 8'h00);
            if (t == 3) begin
                chk("zero d0 sel", {4'h0, bus.io_sel}, 8'h0E);
                chk("zero d0 seg", bus.io_seg, 8'hC0);
            end
            step();
        end
        chk("wrap1 tick", {7'h0, bus.frame_tick}, 8'h01);
        chk("wrap1 pending", {7'h0, bus.pending}, 8'h00);
        step();
        chk("tick one cycle", {7'h0, bus.frame_tick}, 8'h00);
        step_n(-1 + 1);

        // Frame showing 1234 (t=33..64); step above consumed t=33's edge, so
        // re-align by checking the remaining frame from the next frame instead.
        wait_tick("realign");
        check_slot("1234 d0", 4'hE, 8'h19);
        check_slot("1234 d1", 4'hD, 8'hB0);
        check_slot("1234 d2", 4'hB, 8'hA4);
        check_slot("1234 d3", 4'h7, 8'hF9);

        // Load AAAA, then BBBB exactly on the wrap cycle (frame cycle 31).
        do_load(16'hAAAA, 4'h0);
        step_n(30);
        bus.value = 16'hBBBB;
        bus.load  = 1'b1;
        step();
        bus.load  = 1'b0;
        chk("AAAA tick", {7'h0, bus.frame_tick}, 8'h01);
        chk("AAAA still pending", {7'h0, bus.pending}, 8'h01);
        check_slot("AAAA d0", 4'hE, 8'h88);
        step_n(23);
        chk("BBBB pre-wrap pending", {7'h0, bus.pending}, 8'h01);
        step();
        chk("BBBB tick", {7'h0, bus.frame_tick}, 8'h01);
        chk("BBBB pending clear", {7'h0, bus.pending}, 8'h00);
        check_slot("BBBB d0", 4'hE, 8'h83);

        // Digit enables 0101 on display 5678.
        bus.digit_en = 4'b0101;
        do_load(16'h5678, 4'h0);
        wait_tick("5678");
        check_slot("5678 d0", 4'hE, 8'h80);
        check_slot("5678 d1", 4'hF, 8'hFF);
        check_slot("5678 d2", 4'hB, 8'h82);
        check_slot("5678 d3", 4'hF, 8'hFF);
        bus.digit_en = 4'hF;

        // Leading zeros: blanked with SEG_LZB_EN, shown as "0" otherwise.
        do_load(16'h0042, 4'h0);
        wait_tick("0042");
        check_slot("0042 d0", 4'hE, 8'hA4);
        check_slot("0042 d1", 4'hD, 8'h99);
`ifdef SEG_LZB_EN
        check_slot("0042 d2", 4'hB, 8'hFF);
        check_slot("0042 d3", 4'h7, 8'hFF);
`else
        check_slot("0042 d2", 4'hB, 8'hC0);
        check_slot("0042 d3", 4'h7, 8'hC0);
`endif
        do_load(16'h0000, 4'h0);
        wait_tick("0000");
        check_slot("0000 d0", 4'hE, 8'hC0);
`ifdef SEG_LZB_EN
        check_slot("0000 d1", 4'hD, 8'hFF);
        check_slot("0000 d2", 4'hB, 8'hFF);
        check_slot("0000 d3", 4'h7, 8'hFF);
`else
        check_slot("0000 d1", 4'hD, 8'hC0);
        check_slot("0000 d2", 4'hB, 8'hC0);
        check_slot("0000 d3", 4'h7, 8'hC0);
`endif

        // Reset mid-frame discards the pending value and the displayed one.
        do_load(16'h1234, 4'hF);
        chk("pre-rst pending", {7'h0, bus.pending}, 8'h01);
        step_n(5);
        rst = 1'b1;
        step();
        chk("midrst pending", {7'h0, bus.pending}, 8'h00);
        chk("midrst sel", {4'h0, bus.io_sel}, 8'h0F);
        chk("midrst seg", bus.io_seg, 8'hFF);
        chk("midrst tick", {7'h0, bus.frame_tick}, 8'h00);
        rst = 1'b0;
        step_n(3);
        chk("post-rst d0 sel", {4'h0, bus.io_sel}, 8'h0E);
        chk("post-rst d0 seg", bus.io_seg, 8'hC0);
        wait_tick("post-rst");
        chk("post-rst pending", {7'h0, bus.pending}, 8'h00);
        check_slot("post-rst d0", 4'hE, 8'hC0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
